// File: rtl/imem_load_ctrl_if.sv
// Bundle of the loader, fetch and RAM-port signals around imem_load_ctrl.
// master: the environment (program loader, CPU fetch unit, RAM read data).
// slave:  the controller itself.
interface imem_load_ctrl_if #(
   parameter int AW = 10,
   parameter int DW = 32
);

   // Program loader handshake
   logic          ld_start;
   logic [AW:0]   ld_count;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;

   // CPU instruction fetch
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rd;
   logic          if_valid;
   logic          cpu_stall;

   // Status
   logic          busy;
   logic          done;
   logic          load_err;

   // Single RAM port (synchronous write, asynchronous read)
   logic [AW-1:0] mem_a;
   logic          mem_we;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   modport master (
      output ld_start, ld_count, ld_valid, ld_data,
      output if_req, if_addr,
      output mem_rd,
      input  ld_ready, if_rd, if_valid, cpu_stall,
      input  busy, done, load_err,
      input  mem_a, mem_we, mem_wd
   );

   modport slave (
      input  ld_start, ld_count, ld_valid, ld_data,
      input  if_req, if_addr,
      input  mem_rd,
      output ld_ready, if_rd, if_valid, cpu_stall,
      output busy, done, load_err,
      output mem_a, mem_we, mem_wd
   );

endinterface

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: sequencer and arbiter for the single-port instruction RAM.
// A load request zero-fills every RAM word, streams the program in from
// address 0, then gives the port to the CPU fetch path and drops the stall.
// state, ptr, cnt, done and load_err are registered; every other output is
// decoded combinationally from the state, the pointer and the inputs.
module imem_load_ctrl #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            reset,
   imem_load_ctrl_if.slave bus
);

   // DEPTH and DEPTH-1 expressed in the AW+1 bit pointer/count width
   localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] LAST_W  = {1'b0, {AW{1'b1}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      LOAD  = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t        state_reg, state_next;
   logic [AW:0]   ptr_reg, ptr_next;
   logic [AW:0]   cnt_reg, cnt_next;
   logic          done_reg, done_next;
   logic          load_err_reg, load_err_next;

   logic [AW:0]   ptr_inc;
   logic          count_ok;
   logic          start_window;
   logic          fetch_en;

   logic          ld_ready_c;
   logic          mem_we_c;
   logic [AW-1:0] mem_a_c;
   logic [DW-1:0] mem_wd_c;
   logic          busy_c;
   logic          cpu_stall_c;
   logic          if_valid_c;

   // ptr never exceeds DEPTH, so the increment cannot wrap in AW+1 bits
   assign ptr_inc      = ptr_reg + 1'b1;
   assign count_ok     = (bus.ld_count != '0) && (bus.ld_count <= DEPTH_W);
   // A new load may only be requested while the RAM is not being rewritten
   assign start_window = (state_reg == IDLE) || (state_reg == RUN);

   // State register and load bookkeeping; reset abandons any clear/load
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         ptr_reg      <= '0;
         cnt_reg      <= '0;
         done_reg     <= 1'b0;
         load_err_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         cnt_reg      <= cnt_next;
         done_reg     <= done_next;
         load_err_reg <= load_err_next;
      end
   end

   // Next-state logic and RAM-port / handshake output decode
   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      cnt_next      = cnt_reg;
      done_next     = 1'b0;
      load_err_next = load_err_reg;

      ld_ready_c    = 1'b0;
      mem_we_c      = 1'b0;
      mem_a_c       = '0;
      mem_wd_c      = '0;
      busy_c        = 1'b0;
      cpu_stall_c   = 1'b1;
      if_valid_c    = 1'b0;

      unique case (state_reg)
         IDLE: begin
            // CPU held, RAM untouched; only a load request moves us on
            cpu_stall_c = 1'b1;
            mem_we_c    = 1'b0;
         end

         CLEAR: begin
            // One zero write per cycle across the whole RAM
            busy_c   = 1'b1;
            mem_we_c = 1'b1;
            mem_a_c  = ptr_reg[AW-1:0];
            mem_wd_c = '0;
            if (ptr_reg == LAST_W) begin
               ptr_next   = '0;
               state_next = LOAD;
            end else begin
               ptr_next = ptr_inc;
            end
         end

         LOAD: begin
            // Always ready; a word is written on each cycle the loader is valid
            busy_c     = 1'b1;
            ld_ready_c = 1'b1;
            mem_we_c   = bus.ld_valid;
            mem_a_c    = ptr_reg[AW-1:0];
            mem_wd_c   = bus.ld_data;
            if (bus.ld_valid) begin
               ptr_next = ptr_inc;
               if (ptr_inc == cnt_reg) begin
                  state_next = RUN;
                  done_next  = 1'b1;
               end
            end
         end

         RUN: begin
            // Port belongs to fetch: zero-latency read through the async RAM
            cpu_stall_c = 1'b0;
            mem_a_c     = bus.if_addr;
            if_valid_c  = bus.if_req;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Load request: legal counts restart the sequence, illegal ones only flag
      if (start_window && bus.ld_start) begin
         if (count_ok) begin
            state_next    = CLEAR;
            ptr_next      = '0;
            cnt_next      = bus.ld_count;
            load_err_next = 1'b0;
         end else begin
            load_err_next = 1'b1;
         end
      end

      // While reset is held, present the idle/reset view and never write
      if (reset) begin
         ld_ready_c  = 1'b0;
         mem_we_c    = 1'b0;
         mem_a_c     = '0;
         mem_wd_c    = '0;
         busy_c      = 1'b0;
         cpu_stall_c = 1'b1;
         if_valid_c  = 1'b0;
      end
   end

   assign fetch_en      = (state_reg == RUN) && !reset;

   assign bus.ld_ready  = ld_ready_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_a     = mem_a_c;
   assign bus.mem_wd    = mem_wd_c;
   assign bus.busy      = busy_c;
   assign bus.cpu_stall = cpu_stall_c;
   assign bus.if_valid  = if_valid_c;
   assign bus.if_rd     = fetch_en ? bus.mem_rd : '0;
   assign bus.done      = done_reg;
   assign bus.load_err  = load_err_reg;

endmodule
